// File: rtl/param_sampler_pkg.sv
// Shared definitions for the parametrised bit sampler: output-mode encoding
// and the saturating counter increment used by every lane.
package param_sampler_pkg;

    typedef enum logic [1:0] {
        MODE_LEVEL  = 2'd0,
        MODE_RISE   = 2'd1,
        MODE_TOGGLE = 2'd2,
        MODE_BAD    = 2'd3
    } mode_e;

    function automatic mode_e mode_of(input string m);
        if (m == "LEVEL")  return MODE_LEVEL;
        if (m == "RISE")   return MODE_RISE;
        if (m == "TOGGLE") return MODE_TOGGLE;
        return MODE_BAD;
    endfunction

    // Callers keep only the low 'width' bits of the result.
    function automatic logic [15:0] sat_inc(input logic [15:0] val, input int unsigned width);
        logic [16:0] max_val;
        max_val = (17'd1 << width) - 17'd1;
        return ({1'b0, val} == max_val) ? val : val + 16'd1;
    endfunction

endpackage

// File: rtl/sampler_lane.sv
// One sampling lane: two sample stages, the mode-dependent output bit and a
// saturating rising-edge counter.
module sampler_lane
    import param_sampler_pkg::*;
#(
    parameter int    WIDTH     = 1,
    parameter string MODE      = "LEVEL",
    parameter int    CNT_WIDTH = 4,
    parameter int    SEL_W     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 valid,
    input  logic [SEL_W-1:0]     sel,
    input  logic [WIDTH-1:0]     lane_bits,
    output logic                 o_bit,
    output logic [CNT_WIDTH-1:0] cnt
);

    localparam mode_e MODE_ENC = mode_of(MODE);

    logic                 s1_q, s1_d;
    logic                 s2_q, s2_d;
    logic                 o_q, o_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 rise;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            o_q   <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            o_q   <= o_d;
            cnt_q <= cnt_d;
        end
    end

    // Rises are masked until the valid pipe is full so the first sample after
    // reset never counts as an edge.
    always_comb begin
        s1_d  = s1_q;
        s2_d  = s2_q;
        o_d   = o_q;
        cnt_d = cnt_q;
        rise  = en & valid & s1_q & ~s2_q;
        if (en) begin
            s1_d = lane_bits[sel];
            s2_d = s1_q;
        end
        if (MODE_ENC == MODE_RISE) begin
            o_d = rise;
        end else if (MODE_ENC == MODE_TOGGLE) begin
            o_d = o_q ^ rise;
        end else if (en) begin
            o_d = s1_q;
        end
        if (rise) begin
            cnt_d = CNT_WIDTH'(sat_inc(16'(cnt_q), CNT_WIDTH));
        end
    end

    assign o_bit = o_q;
    assign cnt   = cnt_q;

endmodule

// File: rtl/param_bit_sampler.sv
// Multi-lane bit sampler: owns the shared select register and valid pipe and
// instantiates one sampler_lane per channel.
module param_bit_sampler
    import param_sampler_pkg::*;
#(
    parameter int         WIDTH     = 1,
    parameter int         CHANNELS  = 2,
    parameter string      MODE      = "LEVEL",
    parameter logic [7:0] SEL_INIT  = 8'd0,
    parameter int         CNT_WIDTH = 4,
    localparam int        SEL_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          sel_load,
    input  logic [SEL_W-1:0]              sel_in,
    input  logic [CHANNELS*WIDTH-1:0]     I,
    output logic [CHANNELS-1:0]           O,
    output logic                          o_valid,
    output logic [CHANNELS*CNT_WIDTH-1:0] evt_cnt
);

    if (mode_of(MODE) == MODE_BAD) begin : g_bad_mode
        $error("param_bit_sampler: MODE must be LEVEL, RISE or TOGGLE");
    end

    logic [SEL_W-1:0] sel_q, sel_d;
    logic [1:0]       v_q, v_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q <= SEL_INIT[SEL_W-1:0];
            v_q   <= 2'b00;
        end else begin
            sel_q <= sel_d;
            v_q   <= v_d;
        end
    end

    // With WIDTH=1 every load clamps to 0, so the select stays constant.
    always_comb begin
        sel_d = sel_q;
        v_d   = v_q;
        if (sel_load) begin
            sel_d = (32'(sel_in) >= 32'(WIDTH)) ? SEL_W'(WIDTH - 1) : sel_in;
        end
        if (en) begin
            v_d = {v_q[0], 1'b1};
        end
    end

    assign o_valid = v_q[1];

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        sampler_lane #(
            .WIDTH    (WIDTH),
            .MODE     (MODE),
            .CNT_WIDTH(CNT_WIDTH),
            .SEL_W    (SEL_W)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en),
            .valid    (v_q[1]),
            .sel      (sel_q),
            .lane_bits(I[c*WIDTH +: WIDTH]),
            .o_bit    (O[c]),
            .cnt      (evt_cnt[c*CNT_WIDTH +: CNT_WIDTH])
        );
    end

endmodule

// File: tb/tb_param_bit_sampler.sv
// Directed bench for param_bit_sampler: a vector table for LEVEL mode plus
// hand-written sequences for clamping, RISE/TOGGLE, saturation and gating.
module tb_param_bit_sampler;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        sel_load;
    logic [2:0]  sel_in;
    logic [15:0] i8;
    logic [11:0] i6;
    logic [1:0]  i1;

    logic [1:0]  o_a, o_b, o_r, o_t, o_w;
    logic        v_a, v_b, v_r, v_t, v_w;
    logic [7:0]  cnt_a, cnt_b, cnt_r;
    logic [3:0]  cnt_t;
    logic [7:0]  cnt_w;

    int check_count = 0;
    int pass_count  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    param_bit_sampler #(.WIDTH(8), .CHANNELS(2), .MODE("LEVEL"), .SEL_INIT(8'd3), .CNT_WIDTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .sel_load(sel_load), .sel_in(sel_in),
        .I(i8), .O(o_a), .o_valid(v_a), .evt_cnt(cnt_a));

    param_bit_sampler #(.WIDTH(6), .CHANNELS(2), .MODE("LEVEL"), .SEL_INIT(8'd0), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .sel_load(sel_load), .sel_in(sel_in),
        .I(i6), .O(o_b), .o_valid(v_b), .evt_cnt(cnt_b));

    param_bit_sampler #(.WIDTH(8), .CHANNELS(2), .MODE("RISE"), .SEL_INIT(8'd0), .CNT_WIDTH(4)) dut_r (
        .clk(clk), .rst_n(rst_n), .en(en), .sel_load(sel_load), .sel_in(sel_in),
        .I(i8), .O(o_r), .o_valid(v_r), .evt_cnt(cnt_r));

    param_bit_sampler #(.WIDTH(8), .CHANNELS(2), .MODE("TOGGLE"), .SEL_INIT(8'd0), .CNT_WIDTH(2)) dut_t (
        .clk(clk), .rst_n(rst_n), .en(en), .sel_load(sel_load), .sel_in(sel_in),
        .I(i8), .O(o_t), .o_valid(v_t), .evt_cnt(cnt_t));

    param_bit_sampler #(.WIDTH(1), .CHANNELS(2), .MODE("LEVEL"), .SEL_INIT(8'd0), .CNT_WIDTH(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .en(en), .sel_load(sel_load), .sel_in(sel_in[0]),
        .I(i1), .O(o_w), .o_valid(v_w), .evt_cnt(cnt_w));

    typedef struct {
        logic        rst_n;
        logic        en;
        logic        ld;
        logic [2:0]  sel;
        logic [15:0] i;
        logic [1:0]  exp_o;
        logic        exp_v;
        logic [7:0]  exp_cnt;
    } vec_t;

    typedef struct {
        logic en;
        logic bit0;
        logic exp_r;
        logic exp_t;
    } rise_vec_t;

    vec_t      vecs[20];
    rise_vec_t rvecs[19];

    // Inputs are applied, one rising edge passes, and outputs settle 1 ns later.
    task automatic applyStimulus(input logic rst, input logic e, input logic ld, input logic [2:0] s,
                                 input logic [15:0] v8, input logic [11:0] v6, input logic [1:0] v1);
        rst_n    = rst;
        en       = e;
        sel_load = ld;
        sel_in   = s;
        i8       = v8;
        i6       = v6;
        i1       = v1;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    initial begin
        int pulses;

        rst_n = 1'b0; en = 1'b0; sel_load = 1'b0; sel_in = 3'd0;
        i8 = 16'h0; i6 = 12'h0; i1 = 2'b0;

        vecs[0]  = '{0, 0, 0, 0, 16'h0000, 2'b00, 0, 8'h00};
        vecs[1]  = '{0, 1, 0, 0, 16'h0808, 2'b00, 0, 8'h00};
        vecs[2]  = '{1, 1, 0, 0, 16'h0808, 2'b00, 0, 8'h00};
        vecs[3]  = '{1, 1, 0, 0, 16'h0808, 2'b11, 1, 8'h00};
        vecs[4]  = '{1, 1, 0, 0, 16'h0000, 2'b11, 1, 8'h00};
        vecs[5]  = '{1, 1, 0, 0, 16'h0008, 2'b00, 1, 8'h00};
        vecs[6]  = '{1, 1, 0, 0, 16'h0008, 2'b01, 1, 8'h01};
        vecs[7]  = '{1, 1, 0, 0, 16'h0800, 2'b01, 1, 8'h01};
        vecs[8]  = '{1, 1, 0, 0, 16'h0800, 2'b10, 1, 8'h11};
        vecs[9]  = '{1, 0, 0, 0, 16'h0008, 2'b10, 1, 8'h11};
        vecs[10] = '{1, 0, 0, 0, 16'h0808, 2'b10, 1, 8'h11};
        vecs[11] = '{1, 0, 0, 0, 16'h0000, 2'b10, 1, 8'h11};
        vecs[12] = '{1, 0, 0, 0, 16'h00ff, 2'b10, 1, 8'h11};
        vecs[13] = '{1, 1, 0, 0, 16'h0000, 2'b10, 1, 8'h11};
        vecs[14] = '{1, 1, 1, 5, 16'h2020, 2'b00, 1, 8'h11};
        vecs[15] = '{1, 1, 0, 0, 16'h2020, 2'b00, 1, 8'h11};
        vecs[16] = '{1, 1, 0, 0, 16'h2020, 2'b11, 1, 8'h22};
        vecs[17] = '{0, 1, 1, 1, 16'h2020, 2'b00, 0, 8'h00};
        vecs[18] = '{1, 1, 0, 0, 16'h0808, 2'b00, 0, 8'h00};
        vecs[19] = '{1, 1, 0, 0, 16'h0808, 2'b11, 1, 8'h00};

        rvecs[0]  = '{1, 0, 0, 0};
        rvecs[1]  = '{1, 1, 0, 0};
        rvecs[2]  = '{1, 1, 1, 1};
        rvecs[3]  = '{1, 0, 0, 1};
        rvecs[4]  = '{1, 1, 0, 1};
        rvecs[5]  = '{1, 0, 1, 0};
        rvecs[6]  = '{1, 0, 0, 0};
        rvecs[7]  = '{1, 1, 0, 0};
        rvecs[8]  = '{1, 0, 1, 1};
        rvecs[9]  = '{1, 1, 0, 1};
        rvecs[10] = '{1, 0, 1, 0};
        rvecs[11] = '{1, 1, 0, 0};
        rvecs[12] = '{1, 0, 1, 1};
        rvecs[13] = '{1, 0, 0, 1};
        rvecs[14] = '{1, 1, 0, 1};
        rvecs[15] = '{0, 0, 0, 1};
        rvecs[16] = '{0, 1, 0, 1};
        rvecs[17] = '{0, 0, 0, 1};
        rvecs[18] = '{1, 0, 1, 0};

        $display("[TB] LEVEL vector table");
        for (int r = 0; r < 20; r++) begin
            applyStimulus(vecs[r].rst_n, vecs[r].en, vecs[r].ld, vecs[r].sel, vecs[r].i, 12'h0, 2'b00);
            checkOutput($sformatf("row%0d O", r), 16'(o_a), 16'(vecs[r].exp_o));
            checkOutput($sformatf("row%0d o_valid", r), 16'(v_a), 16'(vecs[r].exp_v));
            checkOutput($sformatf("row%0d evt_cnt", r), 16'(cnt_a), 16'(vecs[r].exp_cnt));
        end

        $display("[TB] select clamp and WIDTH=1");
        applyStimulus(0, 0, 0, 3'd0, 16'h0, 12'h000, 2'b00);
        applyStimulus(1, 1, 1, 3'd7, 16'h0, 12'h000, 2'b00);
        applyStimulus(1, 1, 0, 3'd0, 16'h0, 12'h820, 2'b10);
        applyStimulus(1, 1, 0, 3'd0, 16'h0, 12'h820, 2'b10);
        checkOutput("clamp bit5 O", 16'(o_b), 16'h3);
        checkOutput("width1 O", 16'(o_w), 16'h2);
        applyStimulus(1, 1, 0, 3'd0, 16'h0, 12'h410, 2'b01);
        applyStimulus(1, 1, 0, 3'd0, 16'h0, 12'h410, 2'b01);
        checkOutput("clamp bit4 O", 16'(o_b), 16'h0);
        checkOutput("width1 O after", 16'(o_w), 16'h1);
        checkOutput("clamp o_valid", 16'(v_b), 16'h1);

        $display("[TB] RISE / TOGGLE sequence");
        applyStimulus(0, 0, 0, 3'd0, 16'h0, 12'h0, 2'b00);
        applyStimulus(1, 1, 0, 3'd0, 16'h0, 12'h0, 2'b00);
        applyStimulus(1, 1, 0, 3'd0, 16'h0, 12'h0, 2'b00);
        checkOutput("rise o_valid primed", 16'(v_r), 16'h1);
        pulses = 0;
        for (int k = 0; k < 19; k++) begin
            applyStimulus(1, rvecs[k].en, 0, 3'd0, {15'd0, rvecs[k].bit0}, 12'h0, 2'b00);
            checkOutput($sformatf("rise c%0d O", k + 1), 16'(o_r), 16'(rvecs[k].exp_r ? 2'b01 : 2'b00));
            checkOutput($sformatf("toggle c%0d O", k + 1), 16'(o_t), 16'(rvecs[k].exp_t ? 2'b01 : 2'b00));
            if (o_r[0]) pulses++;
            if (k == 6) begin
                checkOutput("rise pulses 0,1,1,0,1", 16'(pulses), 16'd2);
                checkOutput("rise cnt lane0 after 2", 16'(cnt_r[3:0]), 16'd2);
                checkOutput("toggle cnt lane0 after 2", 16'(cnt_t[1:0]), 16'd2);
            end
            if (k == 13) begin
                checkOutput("rise cnt lane0 after 5", 16'(cnt_r[3:0]), 16'd5);
                checkOutput("toggle cnt saturated", 16'(cnt_t[1:0]), 16'd3);
            end
        end
        checkOutput("rise cnt lane0 final", 16'(cnt_r[3:0]), 16'd6);
        checkOutput("rise cnt lane1 idle", 16'(cnt_r[7:4]), 16'd0);
        checkOutput("toggle cnt held at max", 16'(cnt_t), 16'h3);
        checkOutput("rise total pulses", 16'(pulses), 16'd6);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
